// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multiport register file.
package regfile_pkg;
  typedef enum logic {INIT, READY} state_t;

  localparam int          REGFILE_DATA_W = 32;
  localparam int          REGFILE_ADDR_W = 10;
  localparam logic [15:0] REGFILE_KEY    = 16'h0032;
endpackage

// File: rtl/regfile_fwd.sv
// Per-port next-word logic: byte-merges an honoured same-cycle write over the
// stored word, then forces zero for the hardwired-zero entry or out-of-range reads.
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W
) (
  input  logic [DATA_W-1:0]   stored,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                hit,
  input  logic                zero,
  input  logic                out_of_range,
  output logic [DATA_W-1:0]   next_word
);
  always_comb begin
    next_word = stored;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (hit && wr_be[i]) next_word[8*i +: 8] = wr_data[8*i +: 8];
    end
    if (zero || out_of_range) next_word = '0;
  end
endmodule

// File: rtl/regfile_multiport.sv
// Register file with two operand read ports and one memory/debug read port,
// byte-enabled writes, write-first forwarding and a post-reset clear sequence.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int          DATA_W    = REGFILE_DATA_W,
  parameter int          ADDR_W    = REGFILE_ADDR_W,
  parameter int          DEPTH     = 1024,
  parameter int          ZERO_REG  = 0,
  parameter logic [15:0] KEY_VALUE = REGFILE_KEY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   reg1,
  input  logic [ADDR_W-1:0]   reg2,
  input  logic [ADDR_W-1:0]   address_to_mem,
  output logic [DATA_W-1:0]   read_reg1,
  output logic [DATA_W-1:0]   read_reg2,
  output logic [DATA_W-1:0]   memory_out,
  output logic                rd_valid,
  output logic                init_busy,
  output logic [15:0]         key_access
);
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   clear_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_ok;
  logic [ADDR_W-1:0]   rd_addr   [3];
  logic [DATA_W-1:0]   next_word [3];
  logic [DATA_W-1:0]   rd_q      [3];

  assign key_access = KEY_VALUE;

  assign wr_ok = (state == READY) && wr_en && ({1'b0, wr_addr} < DEPTH_V) &&
                 !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clear_ptr[IDX_W-1:0]] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wr_be[i]) mem[wr_addr[IDX_W-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_addr[0] = reg1;
  assign rd_addr[1] = reg2;
  assign rd_addr[2] = address_to_mem;

  for (genvar g = 0; g < 3; g++) begin : g_port
    logic [DATA_W-1:0] stored;
    assign stored = mem[rd_addr[g][IDX_W-1:0]];

    regfile_fwd #(.DATA_W(DATA_W)) u_fwd (
      .stored       (stored),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .hit          (wr_ok && (rd_addr[g] == wr_addr)),
      .zero         ((ZERO_REG != 0) && (rd_addr[g] == '0)),
      .out_of_range ({1'b0, rd_addr[g]} >= DEPTH_V),
      .next_word    (next_word[g])
    );
  end

  // rd_valid qualifies the three read outputs: each cycle it is high, the
  // outputs hold the data for the addresses presented one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clear_ptr <= '0;
      init_busy <= 1'b1;
      rd_valid  <= 1'b0;
      for (int p = 0; p < 3; p++) rd_q[p] <= '0;
    end else begin
      rd_valid <= (state == READY);
      case (state)
        INIT: begin
          if (clear_ptr == LAST_IDX) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            clear_ptr <= clear_ptr + 1'b1;
          end
          for (int p = 0; p < 3; p++) rd_q[p] <= '0;
        end
        READY: begin
          for (int p = 0; p < 3; p++) rd_q[p] <= next_word[p];
        end
        default: state <= INIT;
      endcase
    end
  end

  assign read_reg1  = rd_q[0];
  assign read_reg2  = rd_q[1];
  assign memory_out = rd_q[2];
endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized scoreboard bench for regfile_multiport (DEPTH=16, ZERO_REG=1).
module tb_regfile_multiport;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic [AW-1:0] reg1, reg2, address_to_mem;
  logic [DW-1:0] read_reg1, read_reg2, memory_out;
  logic          rd_valid, init_busy;
  logic [15:0]   key_access;

  regfile_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .reg1(reg1), .reg2(reg2),
    .address_to_mem(address_to_mem), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .memory_out(memory_out), .rd_valid(rd_valid),
    .init_busy(init_busy), .key_access(key_access)
  );

  // reference model and scoreboard
  logic [DW-1:0]   model_mem [DEPTH];
  logic [3*DW-1:0] exp_q[$];
  logic [3*DW-1:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    if (a >= DEPTH || a == 0) return '0;
    return model_mem[a];
  endfunction

  function automatic void model_clear();
    foreach (model_mem[i]) model_mem[i] = '0;
  endfunction

  function automatic int pick_addr(input int wa);
    case ($urandom_range(0, 3))
      0:       return wa;
      1:       return $urandom_range(0, DEPTH - 1);
      2:       return $urandom_range(DEPTH, 63);
      default: return $urandom_range(1, DEPTH - 1);
    endcase
  endfunction

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic do_cycle(input logic we, input int wa, input logic [DW-1:0] wd,
                          input logic [3:0] be, input int a1, input int a2, input int a3);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_be = be;
    reg1 = AW'(a1); reg2 = AW'(a2); address_to_mem = AW'(a3);
    if (we && wa < DEPTH && wa != 0)
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[wa][8*i +: 8] = wd[8*i +: 8];
    exp_q.push_back({model_read(a1), model_read(a2), model_read(a3)});
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_reg1"}, read_reg1, '0);
    check({tag, "_read_reg2"}, read_reg2, '0);
    check({tag, "_memory_out"}, memory_out, '0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_init_busy"}, 32'(init_busy), 32'd1);
    check({tag, "_key"}, 32'(key_access), 32'h0032);
  endtask

  // counts INIT cycles after release; abort_at>0 returns early at that cycle
  task automatic init_count(input int abort_at, input bit poke);
    int cycles;
    cycles = 0;
    for (int n = 1; n <= 3 * DEPTH; n++) begin
      if (poke) begin
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hAAAA_AAAA; wr_be = 4'hF;
      end
      @(posedge clk); #1;
      cycles = n;
      check("init_rd_valid", 32'(rd_valid), 32'd0);
      check("init_read_reg1", read_reg1, '0);
      check("init_memory_out", memory_out, '0);
      check("init_key", 32'(key_access), 32'h0032);
      if (n == abort_at) return;
      if (!init_busy) break;
    end
    wr_en = 1'b0;
    check("init_cycles", 32'(cycles), 32'(DEPTH));
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && rd_valid && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("read_reg1", read_reg1, mon_e[3*DW-1:2*DW]);
      check("read_reg2", read_reg2, mon_e[2*DW-1:DW]);
      check("memory_out", memory_out, mon_e[DW-1:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wa, we;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
    reg1 = '0; reg2 = '0; address_to_mem = '0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");

    // release, with a write attempt to entry 3 throughout INIT
    rst_n = 1'b1;
    init_count(0, 1'b1);
    do_cycle(0, 0, '0, 4'h0, 3, 4, 9);
    check("rd_valid_rise", 32'(rd_valid), 32'd1);
    check("init_busy_low", 32'(init_busy), 32'd0);

    // full-word write then read
    do_cycle(1, 5, 32'hDEAD_BEEF, 4'hF, 0, 6, 1);
    do_cycle(0, 0, '0, 4'h0, 5, 6, 5);
    // partial write forwarded to all ports, then read back
    do_cycle(1, 5, 32'h1234_5678, 4'b0011, 5, 5, 5);
    do_cycle(0, 0, '0, 4'h0, 5, 5, 5);
    // zero entry, out-of-range, last entry, empty byte enables
    do_cycle(1, 0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_cycle(0, 0, '0, 4'h0, 0, 0, 0);
    do_cycle(1, 20, 32'hCAFE_F00D, 4'hF, 20, 20, 20);
    do_cycle(0, 0, '0, 4'h0, 20, 4, 20);
    do_cycle(1, 15, 32'h0BAD_CAFE, 4'hF, 15, 14, 15);
    do_cycle(1, 15, 32'h5555_5555, 4'h0, 15, 15, 15);

    repeat (300) begin
      we = $urandom_range(0, 3) != 0;
      wa = $urandom_range(0, 20);
      do_cycle(1'(we), wa, $urandom, 4'($urandom_range(0, 15)),
               pick_addr(wa), pick_addr(wa), pick_addr(wa));
    end

    // reset mid-operation, then again at INIT cycle 7
    do_cycle(1, 5, 32'h1111_1111, 4'hF, 5, 5, 5);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset1");
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_count(7, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_count(0, 1'b0);
    do_cycle(0, 0, '0, 4'h0, 5, 5, 5);
    check("rd_valid_rise2", 32'(rd_valid), 32'd1);
    repeat (40) begin
      wa = $urandom_range(1, DEPTH - 1);
      do_cycle(1, wa, $urandom, 4'hF, pick_addr(wa), 5, pick_addr(wa));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised register file and memory-read block with three registered read ports: two operand ports and one memory/debug port. It adds a write enable, per-byte write enables, a hardwired-zero entry option, same-cycle write-to-read forwarding and a post-reset clear sequencer. It sits between the datapath write-back stage and the operand/memory consumers, and replaces the fixed 1024x32 always-write register file.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 10, address width in bits
DEPTH, 1024, number of entries; must be <= 2**ADDR_W
ZERO_REG, 0, when 1, entry 0 is hardwired to zero
KEY_VALUE, 16'h0032, constant driven on key_access

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request, honoured only in READY
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
reg1  input  ADDR_W  read port 1 address
reg2  input  ADDR_W  read port 2 address
address_to_mem  input  ADDR_W  memory/debug read address
read_reg1  output  DATA_W  registered read data, port 1
read_reg2  output  DATA_W  registered read data, port 2
memory_out  output  DATA_W  registered read data, memory port
rd_valid  output  1  the read outputs hold valid READY-state data
init_busy  output  1  the clear sequence is in progress
key_access  output  16  constant KEY_VALUE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=INIT, clear_ptr=0.
  - read_reg1, read_reg2 and memory_out = 0.
  - rd_valid=0, init_busy=1.
  - Reset asserted at any point, including mid-INIT or mid-write, restarts the clear sequence from entry 0.
  - A write in the cycle where reset asserts is lost.
- INIT state:
  - Each cycle, write 0 to mem[clear_ptr], then clear_ptr++.
  - When clear_ptr==DEPTH-1, that entry is cleared and state becomes READY on the next edge.
  - Total INIT duration is DEPTH cycles after rst_n deasserts. init_busy drops on the same edge that enters READY.
  - wr_en is ignored during INIT.
  - Read outputs hold 0 and rd_valid=0.
- READY state: stays in READY until reset.
- Write (READY, wr_en=1):
  - On the rising edge, each byte i of mem[wr_addr] with wr_be[i]=1 takes wr_data byte i; other bytes keep their old value.
  - wr_be=0 is a no-op.
  - The write is dropped if wr_addr>=DEPTH, or if ZERO_REG=1 and wr_addr==0.
- Read (all three ports, every READY cycle):
  - One-cycle latency: an address presented in cycle N gives data at the output after edge N+1.
  - Forwarding: if a port's address equals wr_addr and the write is honoured in the same cycle, the port returns the byte-merged new value (write-first), not the stale entry.
  - Reads of an address >=DEPTH return 0.
  - With ZERO_REG=1, reads of address 0 return 0.
  - All three ports may read the same address in the same cycle; each returns the identical value.
- rd_valid: registered copy of (state==READY). It rises one cycle after init_busy falls.
- key_access: continuously KEY_VALUE, independent of reset and state.
- Width rules:
  - Address comparisons use the full ADDR_W bits.
  - clear_ptr is ADDR_W bits wide and does not wrap.

Decomposition:
- Shared package regfile_pkg:
  - state enum {INIT, READY}
  - default constants REGFILE_DATA_W=32, REGFILE_ADDR_W=10, REGFILE_KEY=16'h0032
- Sub-module regfile_fwd: combinational byte-merge and forwarding mux. It takes the stored word, wr_data, wr_be and the hit/zero/out-of-range flags, and returns the next output word. Instantiate it once per read port (three copies).
- The clear FSM, storage array and output registers live in the top module.

Test Plan:
1. DEPTH=16: release rst_n and count cycles. Required: init_busy=1 for exactly 16 cycles, rd_valid rises 1 cycle later, all reads return 0x00000000, key_access=0x0032 throughout, including while reset is held.
2. Write 0xDEADBEEF to address 5 with wr_be=4'hF, then set reg1=5 on the next cycle. Required: read_reg1=0xDEADBEEF one cycle after the address; read_reg2 (reg2=6)=0.
3. With entry 5=0xDEADBEEF, present wr_en=1, wr_addr=5, wr_data=0x12345678, wr_be=4'b0011 together with reg1=reg2=address_to_mem=5 in the same cycle. Required: all three outputs=0xDEAD5678 after the next edge, and a later read also returns 0xDEAD5678.
4. ZERO_REG=1: write 0xFFFFFFFF to address 0. Required: reads of address 0 return 0. Then write address 20 with DEPTH=16. Required: ignored, and reading address 20 returns 0.
5. Assert wr_en with 0xAAAAAAAA to address 3 during INIT. Required: after INIT, address 3 reads 0.
6. Write 0x11111111 to address 5, then pulse rst_n low for 1 cycle mid-operation and again at INIT cycle 7. Required: outputs go to 0 immediately (asynchronously), INIT restarts and lasts the full 16 cycles from the last release, and address 5 then reads 0.
